draw_scheduler: RTL

//  Frame-level sequencer for the instance read port of the raster memory.
//  On each frame_start it walks instance IDs 1..inst_hi-1 (ID 0 = camera), issues one rd_en pulse per ID,

---
 rtl/draw_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/draw_scheduler.sv
// draw_scheduler: frame-level sequencer for the raster-memory instance read port.
// On each accepted frame_start it walks instance IDs 1..lim-1, issuing one rd_en pulse
// per ID and waiting for that instance's stream_done (or a watchdog expiry) before
// advancing. All outputs are registered.
// Optional feature macro: CAM_FIRST_EN -- issue the camera (ID 0) first and expose cam_phase_o.
module draw_scheduler #(
    parameter int MAX_INST  = 256,
    parameter int IDW       = $clog2(MAX_INST),
    parameter int TIMEOUT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_start_i,
    input  logic           abort_i,
    input  logic           pause_i,
    input  logic [IDW-1:0] inst_hi_i,
    input  logic           stream_done_i,
    output logic           rd_en_o,
    output logic [IDW-1:0] rd_inst_id_o,
    output logic           busy_o,
    output logic           frame_done_o,
    output logic           overrun_o,
`ifdef CAM_FIRST_EN
    output logic           cam_phase_o,
`endif
    output logic           timeout_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Watchdog value seen during the last allowed WAIT cycle; the count reaches
    // all-ones at the end of that cycle, which is the expiry point.
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_e               state_q, state_d;
    logic [IDW-1:0]       lim_q, lim_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 rd_en_q, rd_en_d;
    logic [IDW-1:0]       rd_id_q, rd_id_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overrun_q, overrun_d;
    logic                 terr_q, terr_d;
    logic                 last_s;
`ifdef CAM_FIRST_EN
    logic                 cam_q, cam_d;
`endif

    // Next-state and registered-output decode for the frame walk.
    always_comb begin
        state_d      = state_q;
        lim_d        = lim_q;
        id_d         = id_q;
        wdog_d       = wdog_q;
        rd_en_d      = 1'b0;
        rd_id_d      = rd_id_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        terr_d       = terr_q;
`ifdef CAM_FIRST_EN
        cam_d        = cam_q;
`endif
        // lim<=1 only reaches WAIT for the camera slot; otherwise the last ID is lim-1.
        last_s = (lim_q <= IDW'(1)) || (id_q == (lim_q - IDW'(1)));

        if (abort_i) begin
            // Abort beats everything, including a same-cycle frame_start; sticky flags stay.
            state_d = ST_IDLE;
`ifdef CAM_FIRST_EN
            cam_d   = 1'b0;
`endif
        end else begin
            if (frame_start_i && (state_q != ST_IDLE)) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        lim_d     = inst_hi_i;
                        overrun_d = 1'b0;
                        terr_d    = 1'b0;
`ifdef CAM_FIRST_EN
                        id_d      = {IDW{1'b0}};
                        state_d   = ST_ISSUE;
`else
                        id_d      = IDW'(1);
                        state_d   = (inst_hi_i <= IDW'(1)) ? ST_DONE : ST_ISSUE;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (!pause_i) begin
                        rd_en_d = 1'b1;
                        rd_id_d = id_q;
                        wdog_d  = {TIMEOUT_W{1'b0}};
                        state_d = ST_WAIT;
`ifdef CAM_FIRST_EN
                        cam_d   = (id_q == {IDW{1'b0}});
`endif
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    wdog_d = wdog_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                    if (stream_done_i || (wdog_q == WDOG_LAST)) begin
                        // A done on the expiry cycle counts as a normal completion.
                        terr_d = terr_q | ~stream_done_i;
`ifdef CAM_FIRST_EN
                        cam_d  = 1'b0;
`endif
                        if (last_s) begin
                            state_d = ST_DONE;
                        end else begin
                            id_d    = id_q + IDW'(1);
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lim_q        <= {IDW{1'b0}};
            id_q         <= {IDW{1'b0}};
            wdog_q       <= {TIMEOUT_W{1'b0}};
            rd_en_q      <= 1'b0;
            rd_id_q      <= {IDW{1'b0}};
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            terr_q       <= 1'b0;
`ifdef CAM_FIRST_EN
            cam_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lim_q        <= lim_d;
            id_q         <= id_d;
            wdog_q       <= wdog_d;
            rd_en_q      <= rd_en_d;
            rd_id_q      <= rd_id_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            terr_q       <= terr_d;
`ifdef CAM_FIRST_EN
            cam_q        <= cam_d;
`endif
        end
    end

    assign rd_en_o       = rd_en_q;
    assign rd_inst_id_o  = rd_id_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;
    assign overrun_o     = overrun_q;
    assign timeout_err_o = terr_q;
`ifdef CAM_FIRST_EN
    assign cam_phase_o   = cam_q;
`endif

endmodule
